// File: rtl/mem_arbiter.sv
// Two-master arbiter sharing one word-wide memory port between the I-cache
// and D-cache CMUs; a master keeps the port for as long as its cs stays high.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_cs_i,
    input  logic                  m0_we_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [DATA_WIDTH-1:0] m0_data_i,
    output logic [DATA_WIDTH-1:0] m0_data_o,
    output logic                  m0_ack_o,
    input  logic                  m1_cs_i,
    input  logic                  m1_we_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [DATA_WIDTH-1:0] m1_data_i,
    output logic [DATA_WIDTH-1:0] m1_data_o,
    output logic                  m1_ack_o,
    output logic                  mem_cs_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    input  logic                  mem_ack_i,
    output logic [1:0]            arb_state,
    output logic                  last_owner
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_OWN0   = 2'd1,
        S_OWN1   = 2'd2,
        S_UNUSED = 2'd3
    } state_t;

    typedef struct packed {
        logic                  cs;
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } mreq_t;

    state_t state, state_nxt;
    logic   last_nxt;
    logic   owning, owner_sel;
    mreq_t  req [2];

    assign req[0] = '{cs: m0_cs_i, we: m0_we_i, addr: m0_addr_i, data: m0_data_i};
    assign req[1] = '{cs: m1_cs_i, we: m1_we_i, addr: m1_addr_i, data: m1_data_i};

    assign owning    = (state == S_OWN0) || (state == S_OWN1);
    assign owner_sel = (state == S_OWN1);
    assign arb_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            last_owner <= 1'b1;
        end else begin
            state      <= state_nxt;
            last_owner <= last_nxt;
        end
    end

    // Grant decisions use only cs inputs and registered state, never mem_ack_i.
    always_comb begin
        state_nxt = state;
        last_nxt  = last_owner;
        case (state)
            S_IDLE: begin
                if (m0_cs_i && m1_cs_i) begin
                    if (FIXED_PRIO != 0 || !last_owner) begin
                        state_nxt = S_OWN1;
                        last_nxt  = 1'b1;
                    end else begin
                        state_nxt = S_OWN0;
                        last_nxt  = 1'b0;
                    end
                end else if (m0_cs_i) begin
                    state_nxt = S_OWN0;
                    last_nxt  = 1'b0;
                end else if (m1_cs_i) begin
                    state_nxt = S_OWN1;
                    last_nxt  = 1'b1;
                end
            end
            S_OWN0:  if (!m0_cs_i) state_nxt = S_IDLE;
            S_OWN1:  if (!m1_cs_i) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Read data is broadcast; only the acked owner samples it.
    always_comb begin
        mem_cs_o   = 1'b0;
        mem_we_o   = 1'b0;
        mem_addr_o = '0;
        mem_data_o = '0;
        m0_ack_o   = 1'b0;
        m1_ack_o   = 1'b0;
        m0_data_o  = mem_data_i;
        m1_data_o  = mem_data_i;
        if (!rst && owning) begin
            mem_cs_o   = req[owner_sel].cs;
            mem_we_o   = req[owner_sel].we;
            mem_addr_o = req[owner_sel].addr;
            mem_data_o = req[owner_sel].data;
            m0_ack_o   = mem_ack_i & ~owner_sel;
            m1_ack_o   = mem_ack_i & owner_sel;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a round-robin and a fixed-priority instance share
// stimulus and are both tracked every cycle by an ownership-level model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  cs  = '0;
    logic [1:0]  we  = '0;
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [31:0] mdata = '0;
    logic        mack  = 1'b0;

    logic        o_cs [2], o_we [2], o_ack0 [2], o_ack1 [2], o_last [2];
    logic [31:0] o_addr [2], o_data [2], o_rd0 [2], o_rd1 [2];
    logic [1:0]  o_state [2];

    int owner [2];
    int last_m [2];
    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.FIXED_PRIO(0)) u_rr (
        .clk(clk), .rst(rst),
        .m0_cs_i(cs[0]), .m0_we_i(we[0]), .m0_addr_i(addr[0]), .m0_data_i(wdata[0]),
        .m0_data_o(o_rd0[0]), .m0_ack_o(o_ack0[0]),
        .m1_cs_i(cs[1]), .m1_we_i(we[1]), .m1_addr_i(addr[1]), .m1_data_i(wdata[1]),
        .m1_data_o(o_rd1[0]), .m1_ack_o(o_ack1[0]),
        .mem_cs_o(o_cs[0]), .mem_we_o(o_we[0]), .mem_addr_o(o_addr[0]),
        .mem_data_o(o_data[0]), .mem_data_i(mdata), .mem_ack_i(mack),
        .arb_state(o_state[0]), .last_owner(o_last[0])
    );

    mem_arbiter #(.FIXED_PRIO(1)) u_fp (
        .clk(clk), .rst(rst),
        .m0_cs_i(cs[0]), .m0_we_i(we[0]), .m0_addr_i(addr[0]), .m0_data_i(wdata[0]),
        .m0_data_o(o_rd0[1]), .m0_ack_o(o_ack0[1]),
        .m1_cs_i(cs[1]), .m1_we_i(we[1]), .m1_addr_i(addr[1]), .m1_data_i(wdata[1]),
        .m1_data_o(o_rd1[1]), .m1_ack_o(o_ack1[1]),
        .mem_cs_o(o_cs[1]), .mem_we_o(o_we[1]), .mem_addr_o(o_addr[1]),
        .mem_data_o(o_data[1]), .mem_data_i(mdata), .mem_ack_i(mack),
        .arb_state(o_state[1]), .last_owner(o_last[1])
    );

    typedef struct {
        logic r, c0, w0, c1, w1, a;
        logic [1:0] st;
        logic mcs, mwe, k0, k1, lo;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected outputs from who owns the port (-1 = nobody) and current inputs.
    task automatic mcheck();
        int o;
        logic g, e_cs, e_we;
        logic [31:0] e_a, e_d;
        for (int p = 0; p < 2; p++) begin
            o = owner[p];
            g = !rst && (o >= 0);
            e_cs = 1'b0; e_we = 1'b0; e_a = '0; e_d = '0;
            if (g) begin
                e_cs = cs[o]; e_we = we[o]; e_a = addr[o]; e_d = wdata[o];
            end
            chk($sformatf("p%0d mem_cs", p), 32'(o_cs[p]), 32'(e_cs));
            chk($sformatf("p%0d mem_we", p), 32'(o_we[p]), 32'(e_we));
            chk($sformatf("p%0d mem_addr", p), o_addr[p], e_a);
            chk($sformatf("p%0d mem_data", p), o_data[p], e_d);
            chk($sformatf("p%0d m0_ack", p), 32'(o_ack0[p]), 32'(g && o == 0 && mack));
            chk($sformatf("p%0d m1_ack", p), 32'(o_ack1[p]), 32'(g && o == 1 && mack));
            chk($sformatf("p%0d m0_rdata", p), o_rd0[p], mdata);
            chk($sformatf("p%0d m1_rdata", p), o_rd1[p], mdata);
            chk($sformatf("p%0d state", p), 32'(o_state[p]), 32'(o + 1));
            chk($sformatf("p%0d last_owner", p), 32'(o_last[p]), 32'(last_m[p]));
        end
    endtask

    task automatic madv();
        int w;
        for (int p = 0; p < 2; p++) begin
            if (rst) begin
                owner[p] = -1; last_m[p] = 1;
            end else if (owner[p] < 0) begin
                w = -1;
                if (cs[0] && cs[1]) w = (p == 1) ? 1 : 1 - last_m[p];
                else if (cs[0])     w = 0;
                else if (cs[1])     w = 1;
                if (w >= 0) begin owner[p] = w; last_m[p] = w; end
            end else if (!cs[owner[p]]) begin
                owner[p] = -1;
            end
        end
    endtask

    task automatic sample(); #1; mcheck(); endtask
    task automatic step();   @(posedge clk); madv(); @(negedge clk); endtask
    task automatic tick();   sample(); step(); endtask

    task automatic drv(input logic r, c0, w0, c1, w1, a);
        rst = r; cs[0] = c0; we[0] = w0; cs[1] = c1; we[1] = w1; mack = a;
    endtask

    task automatic do_reset();
        drv(1, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        vec_t tbl [17];
        int n0, n1;
        addr[0] = 32'h100; addr[1] = 32'h2000; wdata[0] = 32'hA0; wdata[1] = 32'hB1;
        owner[0] = -1; owner[1] = -1; last_m[0] = 1; last_m[1] = 1;
        @(posedge clk); madv(); @(negedge clk);
        do_reset();

        // Round-robin, release, stall, stray ack and reset mid-transaction.
        tbl[0]  = '{0,1,0,1,1,0, 0,0,0,0,0,1};
        tbl[1]  = '{0,1,0,1,1,0, 1,1,0,0,0,0};
        tbl[2]  = '{0,1,0,1,1,1, 1,1,0,1,0,0};
        tbl[3]  = '{0,0,0,1,1,1, 1,0,0,1,0,0};
        tbl[4]  = '{0,0,0,1,1,1, 0,0,0,0,0,0};
        tbl[5]  = '{0,0,0,1,1,0, 2,1,1,0,0,1};
        tbl[6]  = '{0,0,0,1,1,1, 2,1,1,0,1,1};
        tbl[7]  = '{0,1,0,1,1,0, 2,1,1,0,0,1};
        tbl[8]  = '{0,1,0,0,0,0, 2,0,0,0,0,1};
        tbl[9]  = '{0,1,0,1,1,0, 0,0,0,0,0,1};
        tbl[10] = '{0,1,0,1,1,0, 1,1,0,0,0,0};
        tbl[11] = '{0,0,0,1,1,0, 1,0,0,0,0,0};
        tbl[12] = '{0,0,0,1,1,0, 0,0,0,0,0,0};
        tbl[13] = '{0,0,0,1,1,0, 2,1,1,0,0,1};
        tbl[14] = '{1,0,0,1,1,1, 2,0,0,0,0,1};
        tbl[15] = '{0,0,0,0,0,1, 0,0,0,0,0,1};
        tbl[16] = '{0,0,0,0,0,0, 0,0,0,0,0,1};
        for (int i = 0; i < 17; i++) begin
            drv(tbl[i].r, tbl[i].c0, tbl[i].w0, tbl[i].c1, tbl[i].w1, tbl[i].a);
            sample();
            chk($sformatf("tbl%0d state", i), 32'(o_state[0]), 32'(tbl[i].st));
            chk($sformatf("tbl%0d mem_cs", i), 32'(o_cs[0]), 32'(tbl[i].mcs));
            chk($sformatf("tbl%0d mem_we", i), 32'(o_we[0]), 32'(tbl[i].mwe));
            chk($sformatf("tbl%0d ack0", i), 32'(o_ack0[0]), 32'(tbl[i].k0));
            chk($sformatf("tbl%0d ack1", i), 32'(o_ack1[0]), 32'(tbl[i].k1));
            chk($sformatf("tbl%0d last", i), 32'(o_last[0]), 32'(tbl[i].lo));
            step();
        end

        // Single master 0 read of four words, memory acks two cycles later.
        do_reset();
        n0 = 0; n1 = 0;
        drv(0, 1, 0, 0, 0, 0);
        tick();
        for (int w = 0; w < 4; w++) begin
            addr[0] = 32'h100 + 32'(4 * w);
            mack = 1'b0; tick(); tick();
            mack = 1'b1; mdata = 32'h11 * 32'(w + 1);
            sample();
            chk("rd0 addr", o_addr[0], 32'h100 + 32'(4 * w));
            chk("rd0 ack", 32'(o_ack0[0]), 32'd1);
            chk("rd0 data", o_rd0[0], 32'h11 * 32'(w + 1));
            if (o_ack1[0]) n1++;
            step();
        end
        drv(0, 0, 0, 0, 0, 0);
        tick();
        sample(); chk("rd0 idle after release", 32'(o_state[0]), 32'd0); step();
        chk("rd0 m1 ack count", 32'(n1), 32'd0);

        // Master 1 write-back then refill while master 0 waits.
        do_reset();
        n0 = 0; n1 = 0;
        drv(0, 0, 0, 1, 1, 0);
        tick();
        cs[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            we[1] = (i < 4); addr[1] = 32'h2000 + 32'(4 * (i % 4));
            mack = 1'b0; tick();
            mack = 1'b1; mdata = 32'(i);
            sample();
            if (o_ack1[0]) n1++;
            if (o_ack0[0]) n0++;
            step();
        end
        mack = 1'b0; cs[1] = 1'b0;
        tick();
        sample(); chk("wbf idle", 32'(o_state[0]), 32'd0); step();
        sample(); chk("wbf m0 granted", 32'(o_state[0]), 32'd1); step();
        chk("wbf m1 acks", 32'(n1), 32'd8);
        chk("wbf m0 acks", 32'(n0), 32'd0);
        drv(0, 0, 0, 0, 0, 0);
        tick(); tick();

        // Fixed priority: master 1 wins every simultaneous request.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drv(0, 1, 0, 1, 0, 0);
            tick();
            sample(); chk($sformatf("fp grant %0d", k), 32'(o_state[1]), 32'd2); step();
            drv(0, 0, 0, 0, 0, 0);
            tick(); tick();
        end

        // Random traffic against the model, including occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            for (int k = 0; k < 2; k++) begin
                if (cs[k] && $urandom_range(0, 7) == 0)       cs[k] = 1'b0;
                else if (!cs[k] && $urandom_range(0, 3) == 0) cs[k] = 1'b1;
                we[k] = 1'($urandom_range(0, 1));
                addr[k] = $urandom; wdata[k] = $urandom;
            end
            mack = 1'($urandom_range(0, 1));
            mdata = $urandom;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-master arbiter that shares one word-wide memory port between two cache control units: master 0 is the I-cache CMU, master 1 is the D-cache CMU.
- Each master presents the CMU memory-side handshake (cs/we/addr/data, ack).
- A master owns the port for a whole transaction: every cycle its cs stays high, which covers a write-back followed by a refill.
- Sits between the two CMUs and the memory model or bus bridge.

Parameters:
- ADDR_WIDTH, 32, memory address width.
- DATA_WIDTH, 32, memory data width.
- FIXED_PRIO, 0, 0 = round-robin; 1 = master 1 always wins simultaneous requests.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  synchronous reset, active-high.
- m0_cs_i  in  1  master 0 request / chip select.
- m0_we_i  in  1  master 0 write enable.
- m0_addr_i  in  ADDR_WIDTH  master 0 address.
- m0_data_i  in  DATA_WIDTH  master 0 write data.
- m0_data_o  out  DATA_WIDTH  read data to master 0.
- m0_ack_o  out  1  ack to master 0.
- m1_cs_i, m1_we_i, m1_addr_i, m1_data_i, m1_data_o, m1_ack_o: same as master 0, for master 1.
- mem_cs_o  out  1  memory chip select.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  ADDR_WIDTH  memory address.
- mem_data_o  out  DATA_WIDTH  memory write data.
- mem_data_i  in  DATA_WIDTH  memory read data.
- mem_ack_i  in  1  memory ack, one pulse per completed word.
- arb_state  out  2  debug: current state.
- last_owner  out  1  debug: master most recently granted.

Behaviour:
- States: S_IDLE=0, S_OWN0=1, S_OWN1=2. Encoding 3 is unused and returns to S_IDLE.
- Reset (rst high at posedge):
  - state becomes S_IDLE and last_owner becomes 1, so master 0 wins the first round-robin tie.
  - While rst is high, mem_cs_o, mem_we_o, m0_ack_o and m1_ack_o are forced to 0 combinationally.
  - mem_addr_o and mem_data_o are 0.
- S_IDLE:
  - mem_cs_o=0, mem_we_o=0, mem_addr_o=0, mem_data_o=0; both acks are 0.
  - mem_ack_i is ignored.
  - If exactly one cs_i is high, the next state is that master's OWN state.
  - If both are high:
    - FIXED_PRIO=1: go to S_OWN1.
    - FIXED_PRIO=0: grant the master that is not last_owner.
  - last_owner is updated on the grant edge.
  - Grant latency: a request first seen in S_IDLE at edge N drives mem_cs_o from the cycle after edge N+1 (one arbitration cycle).
- S_OWNx:
  - mem_cs_o, mem_we_o, mem_addr_o, mem_data_o are driven combinationally from master x's inputs.
  - mx_ack_o = mem_ack_i; the other master's ack is 0.
  - mem_data_i is broadcast to both mx_data_o; only the acked master may sample it.
  - Ownership holds while mx_cs_i=1, regardless of the other master and of we toggling mid-transaction (back-then-fill).
  - When mx_cs_i=0 at a posedge, the next state is S_IDLE: mem_cs_o follows cs_i low in the same cycle, and there is one idle turnaround cycle before any new grant.
  - The owner dropping cs in the same cycle as mem_ack_i: the ack is still routed to the owner that cycle.
- A non-owner holding cs_i high is simply stalled: it receives no ack, and its CMU stalls on its own state.
- Reset mid-transaction:
  - Ownership is abandoned and the next state is S_IDLE.
  - A memory ack arriving after reset is dropped.
  - Masters are reset by the same rst.
- No combinational path from mem_ack_i to any mem_* output.
- No starvation in round-robin mode: after an owner releases, a waiting other master is granted before the previous owner is granted again.

Test Plan:
- Single master 0 read:
  - Stimulus: m0_cs_i=1, we=0, addr 0x100..0x10C; memory acks each word after 2 cycles.
  - Required: S_IDLE→S_OWN0; 4 m0_ack_o pulses with data 0x11,0x22,0x33,0x44; m1_ack_o stays 0; back to S_IDLE one cycle after cs drops.
- Simultaneous request, round-robin, out of reset:
  - Stimulus: both cs_i rise together.
  - Required: master 0 granted first (last_owner=1 at reset).
  - After master 0 releases: master 1 is granted after one idle cycle and last_owner=1.
  - Repeat with both requesting again: master 0 wins.
- Hold across write-back then refill:
  - Stimulus: master 1 does 4 writes (we=1, addr 0x2000..) then 4 reads without dropping cs; master 0 requests meanwhile.
  - Required: 8 consecutive m1 acks; master 0 gets no ack until S_IDLE, then S_OWN0.
- FIXED_PRIO=1:
  - Stimulus: both cs_i rise together three times in a row.
  - Required: master 1 is granted each time.
- Reset mid-transaction:
  - Stimulus: assert rst after the 2nd ack of a master 0 read; memory returns an ack during rst.
  - Required: mem_cs_o=0 and both acks 0 while rst=1; state=S_IDLE after rst; the stray ack is not forwarded.
- Stray ack in S_IDLE:
  - Stimulus: pulse mem_ack_i with both cs_i low.
  - Required: both acks 0; state unchanged.
